// File: rtl/eth_tx_frame_arbiter_pkg.sv
// ============================================================================
// Module      : eth_tx_frame_arbiter_pkg
// Description : Shared Ethernet TX bus type and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_tx_frame_arbiter_pkg;

    typedef struct packed {
        logic        start;
        logic        data_valid;
        logic [2:0]  bytes_valid;
        logic [31:0] data;
        logic        commit;
        logic        drop;
    } EthernetTxBus;

    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_WAIT_START = 2'd1,
        ARB_STREAM     = 2'd2
    } arb_state_t;

    localparam int c_word_cnt_w = 10;

endpackage

`default_nettype wire

// File: rtl/eth_tx_frame_arbiter_rr_priority_encoder.sv
// ============================================================================
// Module      : rr_priority_encoder
// Description : Picks the first active request at or after a rotating pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_encoder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         req,
    input  logic [$clog2(WIDTH)-1:0] ptr,
    output logic [WIDTH-1:0]         sel_onehot,
    output logic [$clog2(WIDTH)-1:0] sel_idx,
    output logic                     sel_valid
);

    localparam int c_idx_w = $clog2(WIDTH);

    int w_pos;

    always_comb begin
        sel_onehot = '0;
        sel_idx    = '0;
        sel_valid  = 1'b0;
        w_pos      = 0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pos = int'(ptr) + i;
            if (w_pos >= WIDTH) begin
                w_pos = w_pos - WIDTH;
            end
            if (!sel_valid && req[c_idx_w'(w_pos)]) begin
                sel_valid                     = 1'b1;
                sel_onehot[c_idx_w'(w_pos)]   = 1'b1;
                sel_idx                       = c_idx_w'(w_pos);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/eth_tx_frame_arbiter.sv
// ============================================================================
// Module      : eth_tx_frame_arbiter
// Description : Frame-granular round-robin arbiter sharing one TX MAC port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_tx_frame_arbiter
    import eth_tx_frame_arbiter_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int START_TIMEOUT = 16,
    parameter int MAX_WORDS     = 383
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant,
    input  EthernetTxBus         port_tx_bus [NUM_PORTS],
    output EthernetTxBus         mac_tx_bus,
    input  logic                 mac_tx_ready,
    output logic                 err_timeout,
    output logic                 err_oversize
);

    localparam int c_idx_w = $clog2(NUM_PORTS);
    localparam int c_wd_w  = $clog2(START_TIMEOUT + 1);

    arb_state_t                r_state,   w_state_nxt;
    logic [NUM_PORTS-1:0]      r_grant,   w_grant_nxt;
    logic [c_idx_w-1:0]        r_sel,     w_sel_nxt;
    logic [c_idx_w-1:0]        r_rr,      w_rr_nxt;
    logic [c_wd_w-1:0]         r_wdog,    w_wdog_nxt;
    logic [c_word_cnt_w-1:0]   r_cnt,     w_cnt_nxt;
    logic                      r_fdrop,   w_fdrop_nxt;
    EthernetTxBus              r_bus,     w_bus_nxt;
    logic                      r_err_to,  w_err_to_nxt;
    logic                      r_err_ov,  w_err_ov_nxt;
    logic                      w_end;

    logic [NUM_PORTS-1:0]      w_enc_onehot;
    logic [c_idx_w-1:0]        w_enc_idx;
    logic                      w_enc_valid;
    EthernetTxBus              w_gbus;

    rr_priority_encoder #(
        .WIDTH      (NUM_PORTS)
    ) u_rr_enc (
        .req        (req),
        .ptr        (r_rr),
        .sel_onehot (w_enc_onehot),
        .sel_idx    (w_enc_idx),
        .sel_valid  (w_enc_valid)
    );

    assign w_gbus = port_tx_bus[r_sel];

    function automatic logic [c_idx_w-1:0] f_next_ptr(input logic [c_idx_w-1:0] p);
        if (int'(p) == NUM_PORTS - 1) begin
            return '0;
        end
        return p + c_idx_w'(1);
    endfunction

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_sel_nxt    = r_sel;
        w_rr_nxt     = r_rr;
        w_wdog_nxt   = r_wdog;
        w_cnt_nxt    = r_cnt;
        w_fdrop_nxt  = r_fdrop;
        w_bus_nxt    = '0;
        w_err_to_nxt = 1'b0;
        w_err_ov_nxt = 1'b0;
        w_end        = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (mac_tx_ready && w_enc_valid) begin
                    w_grant_nxt = w_enc_onehot;
                    w_sel_nxt   = w_enc_idx;
                    w_wdog_nxt  = '0;
                    w_state_nxt = ARB_WAIT_START;
                end
            end
            ARB_WAIT_START: begin
                // Anything other than start from the granted port is discarded here.
                if (w_gbus.start) begin
                    w_bus_nxt.start = 1'b1;
                    w_cnt_nxt       = '0;
                    w_fdrop_nxt     = 1'b0;
                    w_state_nxt     = ARB_STREAM;
                end else if (r_wdog == c_wd_w'(START_TIMEOUT - 1)) begin
                    w_grant_nxt  = '0;
                    w_err_to_nxt = 1'b1;
                    w_rr_nxt     = f_next_ptr(r_sel);
                    w_state_nxt  = ARB_IDLE;
                end else begin
                    w_wdog_nxt = r_wdog + c_wd_w'(1);
                end
            end
            ARB_STREAM: begin
                if (r_fdrop) begin
                    // Already dropped on the MAC side; just wait for the port to finish.
                    w_end = w_gbus.start | w_gbus.commit | w_gbus.drop;
                end else if (w_gbus.start) begin
                    w_bus_nxt.drop = 1'b1;
                    w_end          = 1'b1;
                end else if (w_gbus.data_valid && (r_cnt == c_word_cnt_w'(MAX_WORDS))) begin
                    w_bus_nxt.drop = 1'b1;
                    w_err_ov_nxt   = 1'b1;
                    w_fdrop_nxt    = 1'b1;
                    w_end          = w_gbus.commit | w_gbus.drop;
                end else begin
                    w_bus_nxt = w_gbus;
                    if (w_gbus.data_valid) begin
                        w_cnt_nxt = r_cnt + c_word_cnt_w'(1);
                    end
                    w_end = w_gbus.commit | w_gbus.drop;
                end
                if (w_end) begin
                    w_grant_nxt = '0;
                    w_rr_nxt    = f_next_ptr(r_sel);
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_sel    <= '0;
            r_rr     <= '0;
            r_wdog   <= '0;
            r_cnt    <= '0;
            r_fdrop  <= 1'b0;
            r_bus    <= '0;
            r_err_to <= 1'b0;
            r_err_ov <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_sel    <= w_sel_nxt;
            r_rr     <= w_rr_nxt;
            r_wdog   <= w_wdog_nxt;
            r_cnt    <= w_cnt_nxt;
            r_fdrop  <= w_fdrop_nxt;
            r_bus    <= w_bus_nxt;
            r_err_to <= w_err_to_nxt;
            r_err_ov <= w_err_ov_nxt;
        end
    end

    assign grant        = r_grant;
    assign mac_tx_bus   = r_bus;
    assign err_timeout  = r_err_to;
    assign err_oversize = r_err_ov;

endmodule

`default_nettype wire
